// File: rtl/vga_rx_if.sv
// Video port bundle for vga_rx: sync/colour towards the receiver and
// decoded pixel stream plus lock status back from it.
`timescale 1ns/1ps
interface vga_rx_if;
    logic        hs;
    logic        vs;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic [11:0] pixel;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        sof;
    logic        eol;
    logic        locked;
    logic        err;

    modport master (
        output hs, vs, r, g, b,
        input  pixel, pix_valid, pix_x, pix_y, sof, eol, locked, err
    );

    modport slave (
        input  hs, vs, r, g, b,
        output pixel, pix_valid, pix_x, pix_y, sof, eol, locked, err
    );
endinterface

// File: rtl/vga_rx.sv
// VGA receiver: registers sync/colour once, derives line/frame counters from
// sync edge spacing, locks onto the expected geometry and emits active pixels.
`timescale 1ns/1ps
module vga_rx #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 524,
    parameter int H_ACT_START = 144,
    parameter int H_ACT       = 640,
    parameter int V_ACT_START = 32,
    parameter int V_ACT       = 480
) (
    input  logic     clk,
    input  logic     rst_n,
    vga_rx_if.slave  vif
);
    localparam logic [9:0] CNT_MAX = 10'd1023;
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] HA_LO   = 10'(H_ACT_START);
    localparam logic [9:0] HA_HI   = 10'(H_ACT_START + H_ACT - 1);
    localparam logic [9:0] VA_LO   = 10'(V_ACT_START);
    localparam logic [9:0] VA_HI   = 10'(V_ACT_START + V_ACT - 1);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    state_t      r_state, w_state_next;
    logic        r_hs1, r_vs1, r_hs_prev, r_vs_at_ls;
    logic [11:0] r_rgb1;
    logic [9:0]  r_hcnt, r_vcnt, w_hcnt, w_vcnt, w_x;
    logic [8:0]  w_y;
    logic        r_seen_line, r_seen_frame;
    logic        w_line_start, w_frame_start, w_line_bad, w_frame_bad;
    logic        w_mismatch, w_err, w_active, w_valid;
    logic [11:0] r_pixel;
    logic [9:0]  r_pix_x;
    logic [8:0]  r_pix_y;
    logic        r_pix_valid, r_sof, r_eol, r_locked, r_err;

    // Stage 1: sync history resets high so a held-high input never looks like an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs1     <= 1'b1;
            r_vs1     <= 1'b1;
            r_hs_prev <= 1'b1;
            r_rgb1    <= '0;
        end else begin
            r_hs1     <= vif.hs;
            r_vs1     <= vif.vs;
            r_hs_prev <= r_hs1;
            r_rgb1    <= {vif.r, vif.g, vif.b};
        end
    end

    always_comb begin
        w_line_start  = r_hs_prev & ~r_hs1;
        w_frame_start = w_line_start & ~r_vs1 & r_vs_at_ls;
        if (w_line_start)
            w_hcnt = '0;
        else
            w_hcnt = (r_hcnt == CNT_MAX) ? CNT_MAX : r_hcnt + 10'd1;
        if (!w_line_start)
            w_vcnt = r_vcnt;
        else if (w_frame_start)
            w_vcnt = '0;
        else
            w_vcnt = (r_vcnt == CNT_MAX) ? CNT_MAX : r_vcnt + 10'd1;
        // Saturation counts once, on the sample that first reaches the limit
        w_line_bad  = (w_line_start && r_seen_line && (r_hcnt != H_LAST)) ||
                      (!w_line_start && (r_hcnt == CNT_MAX - 10'd1));
        w_frame_bad = (w_frame_start && r_seen_frame && (r_vcnt != V_LAST)) ||
                      (w_line_start && !w_frame_start && (r_vcnt == CNT_MAX - 10'd1));
        w_mismatch  = w_line_bad | w_frame_bad;
    end

    always_comb begin
        w_state_next = r_state;
        w_err        = 1'b0;
        case (r_state)
            SEARCH: if (w_frame_start) w_state_next = CHECK;
            CHECK: begin
                if (w_mismatch)         w_state_next = SEARCH;
                else if (w_frame_start) w_state_next = LOCKED;
            end
            LOCKED: begin
                if (w_mismatch) begin
                    w_state_next = SEARCH;
                    w_err        = 1'b1;
                end
            end
            default: w_state_next = SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= SEARCH;
            r_hcnt       <= CNT_MAX;
            r_vcnt       <= CNT_MAX;
            r_vs_at_ls   <= 1'b1;
            r_seen_line  <= 1'b0;
            r_seen_frame <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_hcnt       <= w_hcnt;
            r_vcnt       <= w_vcnt;
            if (w_line_start) r_vs_at_ls <= r_vs1;
            r_seen_line  <= r_seen_line | w_line_start;
            r_seen_frame <= r_seen_frame | w_frame_start;
        end
    end

    // Gating on the next state drops pix_valid in the very cycle err fires
    always_comb begin
        w_active = (w_hcnt >= HA_LO) && (w_hcnt <= HA_HI) &&
                   (w_vcnt >= VA_LO) && (w_vcnt <= VA_HI);
        w_valid  = w_active && (w_state_next == LOCKED);
        w_x      = w_hcnt - HA_LO;
        w_y      = w_vcnt[8:0] - VA_LO[8:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pixel     <= '0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
            r_pix_valid <= 1'b0;
            r_sof       <= 1'b0;
            r_eol       <= 1'b0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_pix_valid <= w_valid;
            r_sof       <= w_valid && (w_x == '0) && (w_y == '0);
            r_eol       <= w_valid && (w_hcnt == HA_HI);
            r_locked    <= (w_state_next == LOCKED);
            r_err       <= w_err;
            if (w_valid) begin
                r_pixel <= r_rgb1;
                r_pix_x <= w_x;
                r_pix_y <= w_y;
            end
        end
    end

    assign vif.pixel     = r_pixel;
    assign vif.pix_valid = r_pix_valid;
    assign vif.pix_x     = r_pix_x;
    assign vif.pix_y     = r_pix_y;
    assign vif.sof       = r_sof;
    assign vif.eol       = r_eol;
    assign vif.locked    = r_locked;
    assign vif.err       = r_err;
endmodule

// File: tb/tb_vga_rx.sv
// Bench for vga_rx on a reduced geometry: random video stream, reference model
// of sync timing/lock rules feeding scoreboards checked by a separate monitor.
`timescale 1ns/1ps
module tb_vga_rx;
    localparam int HT = 48, VT = 20, HA0 = 12, HACT = 24, VA0 = 3, VACT = 12;
    localparam int HSW = 6, VSW = 2, SAT = 1023, BIG = 1000000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0, n_tests = 0, n_fail = 0;

    vga_rx_if vif();

    vga_rx #(.H_TOTAL(HT), .V_TOTAL(VT), .H_ACT_START(HA0), .H_ACT(HACT),
             .V_ACT_START(VA0), .V_ACT(VACT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vif   (vif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          tag;
        logic [11:0] pixel;
        logic [9:0]  x;
        logic [8:0]  y;
        logic        sof;
        logic        eol;
    } pix_t;
    typedef struct { int tag; logic val; } lk_t;
    typedef enum {HUNT, VERIFY, TRACK} mode_e;

    pix_t pix_q[$];
    lk_t  lk_q[$];
    int   err_q[$];

    // Reference model: ages since the last line/frame start, unbounded
    int    h_age, v_age;
    bit    hs_last, vs_last_ls, seen_line, seen_frame;
    mode_e mode;

    int cur_tag = 0, rst_cycles = 0, abc_tag = -1;
    bit abc_pending = 0, mon_en = 0;
    int win_lo = 1 << 30, win_hi = 1 << 30;
    int cnt_valid = 0, cnt_sof = 0, cnt_eol = 0, n_err_seen = 0;
    logic lock_at_lo = 1'b0, prev_locked = 1'b0;

    function automatic int clamp(input int a);
        return (a > SAT) ? SAT : a;
    endfunction

    task automatic model_reset();
        h_age = BIG; v_age = BIG;
        hs_last = 1; vs_last_ls = 1; seen_line = 0; seen_frame = 0;
        mode = HUNT;
        pix_q.delete(); lk_q.delete(); err_q.delete();
    endtask

    task automatic model_step(input logic h, input logic v, input logic [11:0] c, input int tag);
        bit ls, fs, bad_line, bad_frame;
        mode_e old;
        int hc, vc;
        pix_t p;
        lk_t  l;
        ls = hs_last && !h;
        hs_last = h;
        fs = 0; bad_line = 0; bad_frame = 0;
        if (ls) begin
            if (seen_line && clamp(h_age) + 1 != HT) bad_line = 1;
            seen_line = 1;
            h_age = 0;
            fs = !v && vs_last_ls;
            vs_last_ls = v;
            if (fs) begin
                if (seen_frame && clamp(v_age) + 1 != VT) bad_frame = 1;
                seen_frame = 1;
                v_age = 0;
            end else begin
                v_age++;
                if (v_age == SAT) bad_frame = 1;
            end
        end else begin
            h_age++;
            if (h_age == SAT) bad_line = 1;
        end
        old = mode;
        case (mode)
            HUNT:   if (fs) mode = VERIFY;
            VERIFY: if (bad_line || bad_frame) mode = HUNT; else if (fs) mode = TRACK;
            TRACK:  if (bad_line || bad_frame) begin mode = HUNT; err_q.push_back(tag); end
            default: mode = HUNT;
        endcase
        if ((old == TRACK) != (mode == TRACK)) begin
            l.tag = tag; l.val = (mode == TRACK);
            lk_q.push_back(l);
        end
        hc = clamp(h_age); vc = clamp(v_age);
        if (mode == TRACK && hc >= HA0 && hc < HA0 + HACT && vc >= VA0 && vc < VA0 + VACT) begin
            p.tag = tag; p.pixel = c;
            p.x = 10'(hc - HA0); p.y = 9'(vc - VA0);
            p.sof = (hc == HA0) && (vc == VA0);
            p.eol = (hc == HA0 + HACT - 1);
            pix_q.push_back(p);
        end
    endtask

    task automatic drive(input logic h, input logic v, input logic [11:0] c);
        @(posedge clk); #1;
        if (rst_cycles > 0) begin
            rst_n = 1'b0;
            rst_cycles--;
        end else begin
            rst_n = 1'b1;
        end
        vif.hs = h; vif.vs = v; {vif.r, vif.g, vif.b} = c;
        cur_tag = cyc + 2;
        if (rst_n) model_step(h, v, c, cur_tag);
        else       model_reset();
    endtask

    task automatic send_line(input int len, input int vl, input bit pat, input int rst_h);
        for (int h = 0; h < len; h++) begin
            logic [11:0] c;
            logic [3:0]  xs, ys;
            bit          is_abc;
            if (h == rst_h) rst_cycles = 3;
            xs = 4'(h - HA0);
            ys = 4'(vl - VA0);
            c  = pat ? {xs, ys, 4'h5} : 12'($urandom_range(0, 4095));
            is_abc = abc_pending && (h == HA0) && (vl == VA0);
            if (is_abc) c = 12'hABC;
            drive(h >= HSW, vl >= VSW, c);
            if (is_abc) begin
                abc_tag = cur_tag;
                abc_pending = 0;
            end
        end
    endtask

    task automatic send_frame(input int nlines, input bit pat, input int short_v, input int rst_v);
        for (int v = 0; v < nlines; v++)
            send_line((v == short_v) ? HT - 1 : HT, v, pat, (v == rst_v) ? 20 : -1);
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboards
    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_n) begin
                n_tests++;
                if (vif.pixel !== 12'h0 || vif.pix_valid !== 1'b0 || vif.pix_x !== 10'h0 ||
                    vif.pix_y !== 9'h0 || vif.sof !== 1'b0 || vif.eol !== 1'b0 ||
                    vif.locked !== 1'b0 || vif.err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_outputs cyc=%0d got pix=%h v=%b x=%0d y=%0d sof=%b eol=%b lk=%b err=%b expected all zero",
                             cyc, vif.pixel, vif.pix_valid, vif.pix_x, vif.pix_y, vif.sof, vif.eol, vif.locked, vif.err);
                end
            end else begin
                while (pix_q.size() > 0 && pix_q[0].tag < cyc) begin
                    n_tests++; n_fail++;
                    $display("FAIL pix_missing got=none expected pixel at cyc %0d", pix_q[0].tag);
                    void'(pix_q.pop_front());
                end
                while (err_q.size() > 0 && err_q[0] < cyc) begin
                    n_tests++; n_fail++;
                    $display("FAIL err_missing got=none expected err at cyc %0d", err_q[0]);
                    void'(err_q.pop_front());
                end
                while (lk_q.size() > 0 && lk_q[0].tag < cyc) begin
                    n_tests++; n_fail++;
                    $display("FAIL lock_missing got=none expected locked=%b at cyc %0d", lk_q[0].val, lk_q[0].tag);
                    void'(lk_q.pop_front());
                end
                if (vif.pix_valid === 1'b1) begin
                    n_tests++;
                    if (pix_q.size() == 0 || pix_q[0].tag != cyc) begin
                        n_fail++;
                        $display("FAIL pix_unexpected cyc=%0d got valid=1 expected valid=0", cyc);
                    end else begin
                        pix_t e;
                        e = pix_q.pop_front();
                        if (vif.pixel !== e.pixel || vif.pix_x !== e.x || vif.pix_y !== e.y ||
                            vif.sof !== e.sof || vif.eol !== e.eol) begin
                            n_fail++;
                            $display("FAIL pixel cyc=%0d got pix=%h x=%0d y=%0d sof=%b eol=%b expected pix=%h x=%0d y=%0d sof=%b eol=%b",
                                     cyc, vif.pixel, vif.pix_x, vif.pix_y, vif.sof, vif.eol,
                                     e.pixel, e.x, e.y, e.sof, e.eol);
                        end
                    end
                end
                if (vif.err === 1'b1) begin
                    n_err_seen++;
                    n_tests++;
                    if (err_q.size() == 0 || err_q[0] != cyc || vif.pix_valid !== 1'b0) begin
                        n_fail++;
                        $display("FAIL err_pulse cyc=%0d got err=1 valid=%b expected err at cyc %0d with valid=0",
                                 cyc, vif.pix_valid, (err_q.size() > 0) ? err_q[0] : -1);
                    end else begin
                        void'(err_q.pop_front());
                    end
                end
                if (vif.locked !== prev_locked) begin
                    n_tests++;
                    if (lk_q.size() == 0 || lk_q[0].tag != cyc || lk_q[0].val !== vif.locked) begin
                        n_fail++;
                        $display("FAIL lock_change cyc=%0d got locked=%b expected change at cyc %0d",
                                 cyc, vif.locked, (lk_q.size() > 0) ? lk_q[0].tag : -1);
                    end else begin
                        void'(lk_q.pop_front());
                    end
                end
                if (cyc == abc_tag) begin
                    n_tests++;
                    if (vif.pix_valid !== 1'b1 || vif.pixel !== 12'hABC || vif.pix_x !== 10'd0 ||
                        vif.pix_y !== 9'd0 || vif.sof !== 1'b1) begin
                        n_fail++;
                        $display("FAIL abc_pixel got v=%b pix=%h x=%0d y=%0d sof=%b expected v=1 pix=abc x=0 y=0 sof=1",
                                 vif.pix_valid, vif.pixel, vif.pix_x, vif.pix_y, vif.sof);
                    end
                end
                if (cyc == win_lo) lock_at_lo = vif.locked;
                if (cyc >= win_lo && cyc < win_hi) begin
                    if (vif.pix_valid === 1'b1) cnt_valid++;
                    if (vif.sof === 1'b1)       cnt_sof++;
                    if (vif.eol === 1'b1)       cnt_eol++;
                end
            end
            prev_locked = vif.locked;
        end
    end

    initial begin
        vif.hs = 1'b1; vif.vs = 1'b1; vif.r = '0; vif.g = '0; vif.b = '0;
        model_reset();
        #1;
        rst_n = 1'b0;
        rst_cycles = 4;
        mon_en = 1;
        repeat (7) drive(1'b1, 1'b1, 12'h000);
        send_frame(VT, 1, -1, -1);
        send_frame(VT, 1, -1, -1);
        win_lo = cur_tag + 1;
        send_frame(VT, 1, -1, -1);
        win_hi = cur_tag + 1;
        abc_pending = 1;
        send_frame(VT, 0, -1, -1);
        send_frame(VT, 0, 5, -1);
        repeat (3) send_frame(VT, 0, -1, -1);
        repeat (1100) drive(1'b1, 1'b1, 12'($urandom_range(0, 4095)));
        repeat (3) send_frame(VT, 0, -1, -1);
        send_frame(VT + 1, 0, -1, -1);
        repeat (3) send_frame(VT, 0, -1, -1);
        send_frame(VT, 0, -1, 5);
        repeat (3) send_frame(VT, 0, -1, -1);
        repeat (4) drive(1'b1, 1'b1, 12'h000);
        @(negedge clk);
        check("frame3_lock_at_start", int'(lock_at_lo), 1);
        check("frame3_valid_count", cnt_valid, HACT * VACT);
        check("frame3_sof_count", cnt_sof, 1);
        check("frame3_eol_count", cnt_eol, VACT);
        check("err_pulses_total", n_err_seen, 3);
        check("pix_queue_left", pix_q.size(), 0);
        check("err_queue_left", err_q.size(), 0);
        check("lock_queue_left", lk_q.size(), 0);
        check("final_locked", int'(vif.locked), 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_rx.md
VGA_RX -- requirements
Module: vga_rx

Interface
REQ-001 clk  input  1  pixel clock, 25 MHz; all state SHALL update on its rising edge.
REQ-002 rst_n  input  1  reset, asynchronous and active-low.
REQ-003 hs  input  1  horizontal sync, active-low.
REQ-004 vs  input  1  vertical sync, active-low.
REQ-005 r, g, b  input  4 each  colour inputs, sampled every clk.
REQ-006 pixel  output  12  captured colour {r,g,b}; SHALL be valid only while pix_valid=1.
REQ-007 pix_valid  output  1  high for each active-area pixel while locked.
REQ-008 pix_x  output  10  active-area column, 0..639.
REQ-009 pix_y  output  9  active-area row, 0..479.
REQ-010 sof  output  1  one-cycle pulse, same cycle as pix_valid for pixel (0,0).
REQ-011 eol  output  1  one-cycle pulse, same cycle as pix_valid for pix_x=639.
REQ-012 locked  output  1  timing matches 800x524 geometry.
REQ-013 err  output  1  one-cycle pulse on a geometry mismatch while locked.

Function
REQ-014 Input stage: hs, vs, r, g, b SHALL be registered once (stage 1); all decode SHALL use only stage-1 values.
REQ-015 Output stage: all outputs SHALL be registered (stage 2); input-to-output latency is exactly 2 clk.
REQ-016 Line start: a stage-1 hs falling edge (previous sample 1, current 0) SHALL define hcnt=0 for that sample.
REQ-017 hcnt: 10 bits; SHALL increment every sample after line start; SHALL saturate at 1023, never wrap.
REQ-018 Frame start: at a line start where stage-1 vs=0 and vs was 1 on the previous line start, vcnt SHALL be 0.
REQ-019 At any other line start, vcnt SHALL increment and saturate at 1023.
REQ-020 Active region: hcnt 144..783 and vcnt 32..511 inclusive.
REQ-021 Position: pix_x = hcnt-144; pix_y = (vcnt-32)[8:0].
REQ-022 pix_valid SHALL be 1 only inside the active region while locked=1; pixel, pix_x and pix_y SHALL hold their last values when pix_valid=0.
REQ-023 Line check: at each line start after the first, the previous line length (last hcnt+1) SHALL equal 800; otherwise it is a line mismatch.
REQ-024 Frame check: at each frame start after the first, the previous frame line count (last vcnt+1) SHALL equal 524; otherwise it is a frame mismatch.
REQ-025 The sync hs low width SHALL NOT be checked; only edge spacing SHALL be checked.
REQ-026 Lock FSM states: SEARCH, CHECK, LOCKED.
  - SEARCH: waits for a frame start, then -> CHECK.
  - CHECK: first complete clean frame (no line or frame mismatch) -> LOCKED; any mismatch -> SEARCH.
  - LOCKED: any mismatch -> SEARCH, with err pulsed.
  - locked=1 only in LOCKED.
REQ-027 Missing edges: hcnt reaching 1023 SHALL count as a line mismatch (one per saturation event); vcnt reaching 1023 SHALL count as a frame mismatch.
REQ-028 Simultaneous line and frame mismatch SHALL produce a single err pulse.
REQ-029 On leaving LOCKED, pix_valid SHALL deassert in the same cycle err asserts; a partial line SHALL NOT be emitted.
REQ-030 Lock SHALL first assert at the line start that closes the clean frame, so the first valid pixel is (0,0) of the next frame with sof=1.

Reset
REQ-031 While rst_n=0:
  - pixel=0, pix_valid=0, pix_x=0, pix_y=0, sof=0, eol=0, locked=0, err=0.
  - FSM=SEARCH; hcnt=vcnt=1023.
  - Edge history registers = 1 (no edge is detected on the first sample after reset).
REQ-032 Reset assertion mid-frame SHALL clear all state immediately; after release, lock SHALL require a fresh SEARCH->CHECK->LOCKED sequence.

Verification
REQ-033 Drive a nominal 800x524 stream (hs low 96, vs low 2 lines) with pixel={x[3:0],y[3:0],4'h5} from reset. Required: locked=1 at the end of the 2nd full frame; the 3rd frame gives exactly 307200 pix_valid cycles, sof once, eol 480 times, and pixel values match the pattern.
REQ-034 Locked; feed pixel value 12'hABC at stage-0 hcnt=144, vcnt=32. Required: 2 clk later pix_valid=1, pix_x=0, pix_y=0, pixel=12'hABC, sof=1.
REQ-035 Locked; shorten one line to 799 clocks. Required: err pulses once at the next line start, locked=0 and pix_valid=0 from that cycle, and relock after 2 clean frames.
REQ-036 Locked; hold hs high for 1100 clocks. Required: err pulses when hcnt reaches 1023, and hcnt stays at 1023 until the next hs edge.
REQ-037 Frame of 525 lines. Required: frame mismatch and err=1 at the following frame start.
REQ-038 Assert rst_n=0 for 3 clk mid-line while locked. Required: all outputs 0 within the reset, and locked=0 until 2 frames after release.
